// File: rtl/tug_key_conditioner.sv
// Per-player button front end: two-flop synchronizer, stability debouncer and
// rising-edge press pulse for the left and right keys, with optional tie cancel.
module tug_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIE_CANCEL      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic left_key_n,
  input  logic right_key_n,
  output logic left_press,
  output logic right_press,
  output logic left_held,
  output logic right_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Channel index 0 is the left key, 1 is the right key.
  logic [1:0]    key_s;
  logic [1:0]    s1_r;
  logic [1:0]    s2_r;
  logic [1:0]    db_r;
  logic [1:0]    press_r;
  logic [CW-1:0] cnt_r [0:1];
  logic [1:0]    p_s;
  logic [1:0]    done_s;
  logic [1:0]    rise_s;
  logic [1:0]    press_nxt_s;

  assign key_s = {right_key_n, left_key_n};

  // Acceptance detection, press candidates and same-cycle tie arbitration.
  always_comb begin
    p_s         = ~s2_r;
    done_s      = 2'b00;
    rise_s      = 2'b00;
    press_nxt_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      done_s[i] = (p_s[i] != db_r[i]) && (cnt_r[i] == CNT_LAST);
      rise_s[i] = done_s[i] & p_s[i];
    end
    if ((TIE_CANCEL != 0) && (rise_s == 2'b11)) begin
      press_nxt_s = 2'b00;
    end else begin
      press_nxt_s = rise_s;
    end
  end

  // Synchronizer, debounce counters, accepted levels and press registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_r    <= 2'b11;
      s2_r    <= 2'b11;
      db_r    <= 2'b00;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      s1_r    <= key_s;
      s2_r    <= s1_r;
      press_r <= press_nxt_s;
      for (int i = 0; i < 2; i++) begin
        if (p_s[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (done_s[i]) begin
          db_r[i]  <= p_s[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  assign left_press  = press_r[0];
  assign right_press = press_r[1];
  assign left_held   = db_r[0];
  assign right_held  = db_r[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Bench for tug_key_conditioner: three configurations driven in parallel and
// compared every cycle against a delay-line/sliding-window reference model.
module tb_tug_key_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic left_key_n = 1'b1;
  logic right_key_n = 1'b1;
  logic [2:0] lp, rp, lh, rh;

  always #5 clock = ~clock;

  tug_key_conditioner #(.DEBOUNCE_CYCLES(4), .TIE_CANCEL(1)) dut_a (
    .clock(clock), .reset(reset), .left_key_n(left_key_n), .right_key_n(right_key_n),
    .left_press(lp[0]), .right_press(rp[0]), .left_held(lh[0]), .right_held(rh[0]));
  tug_key_conditioner #(.DEBOUNCE_CYCLES(4), .TIE_CANCEL(0)) dut_b (
    .clock(clock), .reset(reset), .left_key_n(left_key_n), .right_key_n(right_key_n),
    .left_press(lp[1]), .right_press(rp[1]), .left_held(lh[1]), .right_held(rh[1]));
  tug_key_conditioner #(.DEBOUNCE_CYCLES(1), .TIE_CANCEL(1)) dut_c (
    .clock(clock), .reset(reset), .left_key_n(left_key_n), .right_key_n(right_key_n),
    .left_press(lp[2]), .right_press(rp[2]), .left_held(lh[2]), .right_held(rh[2]));

  localparam int DCS [3] = '{4, 4, 1};
  localparam int TCS [3] = '{1, 0, 1};

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: a two-sample delay line per key, a window of the
  // most recent pressed-samples, the accepted level and the press output.
  logic msq  [3][2][2];
  logic mwin [3][2][4];
  logic mdb  [3][2];
  logic mpr  [3][2];

  typedef struct {
    logic rs; logic l; logic r;
    logic lp; logic rp; logic lh; logic rh;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rs, input logic l, input logic r);
    logic kn [2];
    logic rise [2];
    logic p;
    logic all_diff;
    kn[0] = l;
    kn[1] = r;
    for (int i = 0; i < 3; i++) begin
      if (!rs) begin
        for (int c = 0; c < 2; c++) begin
          msq[i][c][0] = 1'b1;
          msq[i][c][1] = 1'b1;
          for (int j = 0; j < 4; j++) mwin[i][c][j] = 1'b0;
          mdb[i][c] = 1'b0;
          mpr[i][c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < 2; c++) begin
          p = ~msq[i][c][1];
          msq[i][c][1] = msq[i][c][0];
          msq[i][c][0] = kn[c];
          for (int j = 3; j > 0; j--) mwin[i][c][j] = mwin[i][c][j-1];
          mwin[i][c][0] = p;
          // A new level is accepted once the last DEBOUNCE_CYCLES samples all differ from it.
          all_diff = 1'b1;
          for (int j = 0; j < DCS[i]; j++)
            if (mwin[i][c][j] == mdb[i][c]) all_diff = 1'b0;
          rise[c] = 1'b0;
          if (all_diff) begin
            mdb[i][c] = p;
            rise[c] = p;
          end
        end
        if (TCS[i] != 0 && rise[0] && rise[1]) begin
          mpr[i][0] = 1'b0;
          mpr[i][1] = 1'b0;
        end else begin
          mpr[i][0] = rise[0];
          mpr[i][1] = rise[1];
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model inst%0d left_press", i), lp[i], mpr[i][0]);
      check($sformatf("model inst%0d right_press", i), rp[i], mpr[i][1]);
      check($sformatf("model inst%0d left_held", i), lh[i], mdb[i][0]);
      check($sformatf("model inst%0d right_held", i), rh[i], mdb[i][1]);
    end
  endtask

  task automatic drive(input logic rs, input logic l, input logic r);
    reset = rs;
    left_key_n = l;
    right_key_n = r;
  endtask

  task automatic tick();
    logic rs, l, r;
    rs = reset;
    l = left_key_n;
    r = right_key_n;
    @(posedge clock);
    model_step(rs, l, r);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    drive(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic void add(input logic rs, l, r, xlp, xrp, xlh, xrh);
    vec_t v;
    v.rs = rs; v.l = l; v.r = r;
    v.lp = xlp; v.rp = xrp; v.lh = xlh; v.rh = xrh;
    tbl.push_back(v);
  endfunction

  initial begin
    int pa, pl, pr, bad;
    logic lv, rv;
    int lrun, rrun;

    // Directed vectors for the default configuration.
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) add(1, 0, 1, k == 5, 0, k >= 5, 0);
    for (int k = 0; k < 10; k++) add(1, 1, 1, 0, 0, k < 5, 0);
    for (int rep = 0; rep < 5; rep++)
      for (int j = 0; j < 4; j++) add(1, 1, j == 3, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) add(1, 1, 0, 0, k == 5, 0, k >= 5);
    for (int k = 0; k < 10; k++) add(1, 1, 1, 0, 0, 0, k < 5);

    foreach (tbl[k]) begin
      drive(tbl[k].rs, tbl[k].l, tbl[k].r);
      tick();
      check($sformatf("vec%0d left_press", k), lp[0], tbl[k].lp);
      check($sformatf("vec%0d right_press", k), rp[0], tbl[k].rp);
      check($sformatf("vec%0d left_held", k), lh[0], tbl[k].lh);
      check($sformatf("vec%0d right_held", k), rh[0], tbl[k].rh);
    end

    // Same-cycle tie: cancelled in A and C, both pulse in B.
    idle(4);
    pa = 0; pl = 0; pr = 0;
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      pa += int'(lp[0]) + int'(rp[0]);
      pl += int'(lp[1]);
      pr += int'(rp[1]);
      if (k == 4) check("tie A held before edge5", lh[0] | rh[0], 1'b0);
      if (k == 5) begin
        check("tie A left_held", lh[0], 1'b1);
        check("tie A right_held", rh[0], 1'b1);
        check("tie B left_press", lp[1], 1'b1);
        check("tie B right_press", rp[1], 1'b1);
      end
      if (k == 2) begin
        check("tie C held both", lh[2] & rh[2], 1'b1);
        check("tie C no press", lp[2] | rp[2], 1'b0);
      end
    end
    check("tie A pulse count zero", pa == 0, 1'b1);
    check("tie B one pulse each", (pl == 1) && (pr == 1), 1'b1);
    idle(10);

    // Keys one cycle apart: both pulse, left first.
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      tick();
      if (k == 5) check("apart k5 press pair", {lp[0], rp[0]} == 2'b10, 1'b1);
      if (k == 6) check("apart k6 press pair", {lp[0], rp[0]} == 2'b01, 1'b1);
    end
    idle(10);

    // Reset during debounce with the key still held.
    drive(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    drive(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("midreset outputs zero", {lp[0], rp[0], lh[0], rh[0]} == 4'b0000, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b1);
    pa = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pa += int'(lp[0]);
      if (k == 5) check("midreset press at edge5", lp[0], 1'b1);
    end
    check("midreset single press", pa == 1, 1'b1);
    idle(10);

    // Long hold: a single pulse, held stays up.
    drive(1'b1, 1'b0, 1'b1);
    pa = 0; bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      pa += int'(lp[0]);
      if (k >= 5 && lh[0] !== 1'b1) bad++;
    end
    check("long hold single press", pa == 1, 1'b1);
    check("long hold held stable", bad == 0, 1'b1);
    idle(10);

    // Random bouncy keys with occasional resets, checked against the model.
    lv = 1'b1; rv = 1'b1; lrun = 0; rrun = 0;
    for (int k = 0; k < 3000; k++) begin
      if (lrun == 0) begin
        lv = 1'($urandom_range(0, 1));
        lrun = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 6));
      end
      if (rrun == 0) begin
        rv = 1'($urandom_range(0, 1));
        rrun = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(1, 6));
      end
      lrun--;
      rrun--;
      drive(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, lv, rv);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
